// File: rtl/lane_vrf_write_pkg.sv
// Shared types and helpers for the lane VRF write stage.
// - DEFAULT_* localparams mirror the module parameter defaults.
// - entry_t is the queue entry layout at those default widths.
// - mapVd() adds the high group-counter bits to the base register.
// - mergeBytes() does a byte-enable merge.
// Both helpers run at generous fixed widths. Callers size-cast their
// arguments and results, so one helper serves any parameterisation.
package lane_vrf_write_pkg;

  localparam int unsigned DEFAULT_DATA_W   = 32;
  localparam int unsigned DEFAULT_MASK_W   = DEFAULT_DATA_W / 8;
  localparam int unsigned DEFAULT_GROUP_W  = 7;
  localparam int unsigned DEFAULT_OFFSET_W = 3;
  localparam int unsigned DEFAULT_VD_W     = 5;
  localparam int unsigned DEFAULT_INST_W   = 3;
  localparam int unsigned DEFAULT_DEPTH    = 4;

  localparam int unsigned MAX_DATA_W  = 1024;
  localparam int unsigned MAX_MASK_W  = MAX_DATA_W / 8;
  localparam int unsigned MAX_VD_W    = 32;
  localparam int unsigned MAX_GROUP_W = 32;

  typedef struct packed {
    logic [DEFAULT_VD_W-1:0]     vd;
    logic [DEFAULT_OFFSET_W-1:0] offset;
    logic [DEFAULT_MASK_W-1:0]   mask;
    logic [DEFAULT_DATA_W-1:0]   data;
    logic                        last;
    logic [DEFAULT_INST_W-1:0]   instIdx;
    logic                        killed;
  } entry_t;

  // The caller truncates the result to its register-index width,
  // which gives the mod 2^VD_W wrap.
  function automatic logic [MAX_VD_W-1:0] mapVd(
    input logic [MAX_VD_W-1:0]    baseVd,
    input logic [MAX_GROUP_W-1:0] groupHigh
  );
    return baseVd + groupHigh;
  endfunction

  function automatic logic [MAX_DATA_W-1:0] mergeBytes(
    input logic [MAX_DATA_W-1:0] oldData,
    input logic [MAX_DATA_W-1:0] newData,
    input logic [MAX_MASK_W-1:0] newMask
  );
    logic [MAX_DATA_W-1:0] res;
    res = oldData;
    for (int unsigned b = 0; b < MAX_MASK_W; b++) begin
      if (newMask[b]) res[b*8 +: 8] = newData[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/lane_vrf_write_buffer.sv
// Circular write queue for the lane VRF write stage.
// - Storage: DEPTH entries addressed by head and tail pointers, with a
//   full flag to tell full from empty.
// - Kill marking: killValid/killInst set the killed bit on every
//   occupied entry whose instruction index matches. An entry pushed in
//   the same cycle with a matching index is also marked.
// - Outputs: head entry fields, empty, full, and count (killed entries
//   are included in count).
// - Push and pop must be qualified by the caller (no push when full,
//   no pop when empty).
// Macro LANE_VRF_WRITE_COALESCE_EN adds ports that expose the youngest
// entry and let the caller merge into it.
module lane_vrf_write_buffer
  import lane_vrf_write_pkg::*;
#(
  parameter  int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter  int unsigned OFFSET_W = DEFAULT_OFFSET_W,
  parameter  int unsigned VD_W     = DEFAULT_VD_W,
  parameter  int unsigned INST_W   = DEFAULT_INST_W,
  parameter  int unsigned DEPTH    = DEFAULT_DEPTH,
  localparam int unsigned MASK_W   = DATA_W / 8,
  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push,
  input  logic [VD_W-1:0]     pushVd,
  input  logic [OFFSET_W-1:0] pushOffset,
  input  logic [MASK_W-1:0]   pushMask,
  input  logic [DATA_W-1:0]   pushData,
  input  logic                pushLast,
  input  logic [INST_W-1:0]   pushInst,
  input  logic                pop,
  input  logic                killValid,
  input  logic [INST_W-1:0]   killInst,
`ifdef LANE_VRF_WRITE_COALESCE_EN
  input  logic                merge,
  input  logic [MASK_W-1:0]   mergeMask,
  input  logic [DATA_W-1:0]   mergeData,
  input  logic                mergeLast,
  output logic [VD_W-1:0]     youngVd,
  output logic [OFFSET_W-1:0] youngOffset,
  output logic [MASK_W-1:0]   youngMask,
  output logic [DATA_W-1:0]   youngData,
  output logic                youngLast,
  output logic [INST_W-1:0]   youngInst,
  output logic                youngKilled,
`endif
  output logic [VD_W-1:0]     headVd,
  output logic [OFFSET_W-1:0] headOffset,
  output logic [MASK_W-1:0]   headMask,
  output logic [DATA_W-1:0]   headData,
  output logic                headLast,
  output logic [INST_W-1:0]   headInst,
  output logic                headKilled,
  output logic                empty,
  output logic                full,
  output logic [CNT_W-1:0]    count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [VD_W-1:0]     vd;
    logic [OFFSET_W-1:0] offset;
    logic [MASK_W-1:0]   mask;
    logic [DATA_W-1:0]   data;
    logic                last;
    logic [INST_W-1:0]   instIdx;
    logic                killed;
  } slot_t;

  slot_t            mem [DEPTH];
  logic [PTR_W-1:0] headPtr;
  logic [PTR_W-1:0] tailPtr;
  logic             fullQ;
  logic [PTR_W-1:0] used;
  logic [DEPTH-1:0] occupied;

  assign used  = tailPtr - headPtr;
  assign full  = fullQ;
  assign empty = ~fullQ & (headPtr == tailPtr);
  assign count = fullQ ? CNT_W'(DEPTH) : {1'b0, used};

  // A slot is occupied when its distance from head is below the fill level.
  always_comb begin
    occupied = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      occupied[i] = fullQ | ((PTR_W'(i) - headPtr) < used);
    end
  end

  assign headVd     = mem[headPtr].vd;
  assign headOffset = mem[headPtr].offset;
  assign headMask   = mem[headPtr].mask;
  assign headData   = mem[headPtr].data;
  assign headLast   = mem[headPtr].last;
  assign headInst   = mem[headPtr].instIdx;
  assign headKilled = mem[headPtr].killed;

`ifdef LANE_VRF_WRITE_COALESCE_EN
  logic [PTR_W-1:0] youngPtr;
  assign youngPtr    = tailPtr - PTR_W'(1);
  assign youngVd     = mem[youngPtr].vd;
  assign youngOffset = mem[youngPtr].offset;
  assign youngMask   = mem[youngPtr].mask;
  assign youngData   = mem[youngPtr].data;
  assign youngLast   = mem[youngPtr].last;
  assign youngInst   = mem[youngPtr].instIdx;
  assign youngKilled = mem[youngPtr].killed;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      fullQ   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (killValid) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (occupied[i] && (mem[i].instIdx == killInst)) mem[i].killed <= 1'b1;
        end
      end
`ifdef LANE_VRF_WRITE_COALESCE_EN
      if (merge) begin
        mem[youngPtr].mask <= mergeMask;
        mem[youngPtr].data <= mergeData;
        mem[youngPtr].last <= mergeLast;
      end
`endif
      if (push) begin
        mem[tailPtr] <= '{vd: pushVd, offset: pushOffset, mask: pushMask,
                          data: pushData, last: pushLast, instIdx: pushInst,
                          killed: killValid && (pushInst == killInst)};
        tailPtr      <= tailPtr + PTR_W'(1);
      end
      if (pop) headPtr <= headPtr + PTR_W'(1);
      if (push && !pop)      fullQ <= ((tailPtr + PTR_W'(1)) == headPtr);
      else if (pop && !push) fullQ <= 1'b0;
    end
  end

endmodule

// File: rtl/lane_vrf_write_stage.sv
// Final lane pipeline stage. It turns execute results into VRF write
// requests.
// - enq_*: result from execute. The group counter maps to (vd, offset).
//   enq_ready is ~full and depends only on state.
// - kill_*: marks every queued write of one instruction as killed.
//   Killed writes are dropped at the head, one per cycle, without
//   raising wr_valid.
// - wr_*: VRF write request, driven directly from the head entry.
// - count: occupied entries, killed entries included.
// Macro LANE_VRF_WRITE_COALESCE_EN: a push merges into the youngest
// entry when that entry is still open (same vd, offset and instruction;
// not last, not killed, and not leaving the queue this cycle).
module lane_vrf_write_stage
  import lane_vrf_write_pkg::*;
#(
  parameter  int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter  int unsigned GROUP_W  = DEFAULT_GROUP_W,
  parameter  int unsigned OFFSET_W = DEFAULT_OFFSET_W,
  parameter  int unsigned VD_W     = DEFAULT_VD_W,
  parameter  int unsigned INST_W   = DEFAULT_INST_W,
  parameter  int unsigned DEPTH    = DEFAULT_DEPTH,
  localparam int unsigned MASK_W   = DATA_W / 8,
  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enq_valid,
  output logic                enq_ready,
  input  logic [GROUP_W-1:0]  enq_groupCounter,
  input  logic [VD_W-1:0]     enq_vd,
  input  logic [DATA_W-1:0]   enq_data,
  input  logic [MASK_W-1:0]   enq_mask,
  input  logic                enq_last,
  input  logic [INST_W-1:0]   enq_instructionIndex,
  input  logic                kill_valid,
  input  logic [INST_W-1:0]   kill_instructionIndex,
  output logic                wr_valid,
  input  logic                wr_ready,
  output logic [VD_W-1:0]     wr_vd,
  output logic [OFFSET_W-1:0] wr_offset,
  output logic [MASK_W-1:0]   wr_mask,
  output logic [DATA_W-1:0]   wr_data,
  output logic                wr_last,
  output logic [INST_W-1:0]   wr_instructionIndex,
  output logic [CNT_W-1:0]    count
);

  logic [VD_W-1:0]     mappedVd;
  logic [OFFSET_W-1:0] mappedOffset;
  logic                headKilled;
  logic                empty;
  logic                full;
  logic                accept;
  logic                doPush;
  logic                pop;

  assign mappedOffset = enq_groupCounter[OFFSET_W-1:0];
  assign mappedVd     = VD_W'(mapVd(MAX_VD_W'(enq_vd),
                                    MAX_GROUP_W'(enq_groupCounter[GROUP_W-1:OFFSET_W])));

  assign enq_ready = ~full;
  assign accept    = enq_valid & ~full;
  assign wr_valid  = ~empty & ~headKilled;
  // A killed head leaves the queue regardless of wr_ready.
  assign pop       = (wr_valid & wr_ready) | (~empty & headKilled);

`ifdef LANE_VRF_WRITE_COALESCE_EN
  logic [VD_W-1:0]     youngVd;
  logic [OFFSET_W-1:0] youngOffset;
  logic [MASK_W-1:0]   youngMask;
  logic [DATA_W-1:0]   youngData;
  logic                youngLast;
  logic [INST_W-1:0]   youngInst;
  logic                youngKilled;
  logic                youngLeaving;
  logic                mergeHit;
  logic                doMerge;
  logic [MASK_W-1:0]   mergeMask;
  logic [DATA_W-1:0]   mergeData;
  logic                mergeLast;

  // The youngest entry leaves only when it is also the head.
  assign youngLeaving = pop & (count == CNT_W'(1));
  assign mergeHit     = ~empty & ~youngLeaving & ~youngKilled & ~youngLast &
                        (youngVd == mappedVd) & (youngOffset == mappedOffset) &
                        (youngInst == enq_instructionIndex);
  assign doMerge      = accept & mergeHit;
  assign doPush       = accept & ~mergeHit;
  assign mergeMask    = youngMask | enq_mask;
  assign mergeLast    = youngLast | enq_last;
  assign mergeData    = DATA_W'(mergeBytes(MAX_DATA_W'(youngData), MAX_DATA_W'(enq_data),
                                           MAX_MASK_W'(enq_mask)));
`else
  assign doPush = accept;
`endif

  lane_vrf_write_buffer #(
    .DATA_W   (DATA_W),
    .OFFSET_W (OFFSET_W),
    .VD_W     (VD_W),
    .INST_W   (INST_W),
    .DEPTH    (DEPTH)
  ) buffer (
    .clock       (clock),
    .reset       (reset),
    .push        (doPush),
    .pushVd      (mappedVd),
    .pushOffset  (mappedOffset),
    .pushMask    (enq_mask),
    .pushData    (enq_data),
    .pushLast    (enq_last),
    .pushInst    (enq_instructionIndex),
    .pop         (pop),
    .killValid   (kill_valid),
    .killInst    (kill_instructionIndex),
`ifdef LANE_VRF_WRITE_COALESCE_EN
    .merge       (doMerge),
    .mergeMask   (mergeMask),
    .mergeData   (mergeData),
    .mergeLast   (mergeLast),
    .youngVd     (youngVd),
    .youngOffset (youngOffset),
    .youngMask   (youngMask),
    .youngData   (youngData),
    .youngLast   (youngLast),
    .youngInst   (youngInst),
    .youngKilled (youngKilled),
`endif
    .headVd      (wr_vd),
    .headOffset  (wr_offset),
    .headMask    (wr_mask),
    .headData    (wr_data),
    .headLast    (wr_last),
    .headInst    (wr_instructionIndex),
    .headKilled  (headKilled),
    .empty       (empty),
    .full        (full),
    .count       (count)
  );

endmodule

// File: tb/tb_lane_vrf_write_stage.sv
// Bench for lane_vrf_write_stage at default parameters.
module tb_lane_vrf_write_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        enq_valid;
  logic        enq_ready;
  logic [6:0]  enq_groupCounter;
  logic [4:0]  enq_vd;
  logic [31:0] enq_data;
  logic [3:0]  enq_mask;
  logic        enq_last;
  logic [2:0]  enq_instructionIndex;
  logic        kill_valid;
  logic [2:0]  kill_instructionIndex;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_vd;
  logic [2:0]  wr_offset;
  logic [3:0]  wr_mask;
  logic [31:0] wr_data;
  logic        wr_last;
  logic [2:0]  wr_instructionIndex;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  lane_vrf_write_stage dut (
    .clock                 (clock),
    .reset                 (reset),
    .enq_valid             (enq_valid),
    .enq_ready             (enq_ready),
    .enq_groupCounter      (enq_groupCounter),
    .enq_vd                (enq_vd),
    .enq_data              (enq_data),
    .enq_mask              (enq_mask),
    .enq_last              (enq_last),
    .enq_instructionIndex  (enq_instructionIndex),
    .kill_valid            (kill_valid),
    .kill_instructionIndex (kill_instructionIndex),
    .wr_valid              (wr_valid),
    .wr_ready              (wr_ready),
    .wr_vd                 (wr_vd),
    .wr_offset             (wr_offset),
    .wr_mask               (wr_mask),
    .wr_data               (wr_data),
    .wr_last               (wr_last),
    .wr_instructionIndex   (wr_instructionIndex),
    .count                 (count)
  );

  initial forever #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pushOne(input logic [4:0] vd, input logic [6:0] gc, input logic [31:0] data,
                         input logic [3:0] mask, input logic last, input logic [2:0] inst);
    enq_vd = vd; enq_groupCounter = gc; enq_data = data; enq_mask = mask;
    enq_last = last; enq_instructionIndex = inst; enq_valid = 1'b1;
    @(negedge clock);
    enq_valid = 1'b0;
  endtask

  // Waits (bounded) for a live head, checks its data, and lets it pop.
  task automatic expectWrite(input string name, input logic [31:0] expData);
    wr_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      if (wr_valid) begin
        check(name, wr_data, expData);
        @(negedge clock);
        wr_ready = 1'b0;
        return;
      end
      @(negedge clock);
    end
    wr_ready = 1'b0;
    check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  typedef struct {
    logic [4:0]  vd;
    logic [6:0]  gc;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [4:0]  expVd;
    logic [2:0]  expOff;
  } mapVec_t;

  typedef struct {
    logic [4:0]  vd;
    logic [2:0]  off;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        last;
    logic [2:0]  inst;
    logic        killed;
  } mEnt_t;

  mapVec_t vecs [5];
  mEnt_t   q [$];

  initial begin
    vecs[0] = '{vd: 5'd5,  gc: 7'h1B, data: 32'hA5A5A5A5, mask: 4'hF, expVd: 5'd8,  expOff: 3'd3};
    vecs[1] = '{vd: 5'd31, gc: 7'h7F, data: 32'h12345678, mask: 4'h1, expVd: 5'd14, expOff: 3'd7};
    vecs[2] = '{vd: 5'd0,  gc: 7'h00, data: 32'hFFFFFFFF, mask: 4'h0, expVd: 5'd0,  expOff: 3'd0};
    vecs[3] = '{vd: 5'd20, gc: 7'h45, data: 32'h0BADF00D, mask: 4'h6, expVd: 5'd28, expOff: 3'd5};
    vecs[4] = '{vd: 5'd30, gc: 7'h50, data: 32'hDEADBEEF, mask: 4'h8, expVd: 5'd8,  expOff: 3'd0};

    reset = 1'b0; enq_valid = 1'b0; wr_ready = 1'b0; kill_valid = 1'b0;
    enq_vd = '0; enq_groupCounter = '0; enq_data = '0; enq_mask = '0;
    enq_last = 1'b0; enq_instructionIndex = '0; kill_instructionIndex = '0;
    repeat (2) @(negedge clock);
    check("rst_valid", wr_valid, 0);
    check("rst_count", count, 0);
    check("rst_ready", enq_ready, 1);
    check("rst_data", wr_data, 0);
    reset = 1'b1;
    @(negedge clock);

    // Address map table
    for (int i = 0; i < 5; i++) begin
      enq_vd = vecs[i].vd; enq_groupCounter = vecs[i].gc; enq_data = vecs[i].data;
      enq_mask = vecs[i].mask; enq_last = 1'b1; enq_instructionIndex = 3'd0; enq_valid = 1'b1;
      #1 check("map_nocomb", wr_valid, 0);
      @(negedge clock);
      enq_valid = 1'b0;
      check("map_valid", wr_valid, 1);
      check("map_vd", wr_vd, vecs[i].expVd);
      check("map_off", wr_offset, vecs[i].expOff);
      check("map_data", wr_data, vecs[i].data);
      check("map_mask", wr_mask, vecs[i].mask);
      wr_ready = 1'b1;
      @(negedge clock);
      wr_ready = 1'b0;
      check("map_drain", count, 0);
    end

    // Full queue and back-pressure
    for (int i = 0; i < 4; i++) pushOne(5'd5, 7'(i), 32'd100 + 32'(i), 4'hF, 1'b1, 3'd0);
    check("full_count", count, 4);
    check("full_ready", enq_ready, 0);
    enq_data = 32'd104; enq_groupCounter = 7'd4; enq_valid = 1'b1;
    @(negedge clock);
    check("full_hold", count, 4);
    check("full_head", wr_data, 100);
    wr_ready = 1'b1;
    @(negedge clock);
    wr_ready = 1'b0;
    check("full_pop_count", count, 3);
    check("full_pop_ready", enq_ready, 1);
    @(negedge clock);
    enq_valid = 1'b0;
    check("full_refill", count, 4);
    for (int i = 1; i < 5; i++) expectWrite("full_order", 32'd100 + 32'(i));
    check("full_empty", count, 0);

    // Kill of instruction 1 among 1,2,1
    pushOne(5'd1, 7'd0, 32'h11, 4'hF, 1'b1, 3'd1);
    pushOne(5'd1, 7'd1, 32'h22, 4'hF, 1'b1, 3'd2);
    pushOne(5'd1, 7'd2, 32'h13, 4'hF, 1'b1, 3'd1);
    kill_valid = 1'b1; kill_instructionIndex = 3'd1;
    @(negedge clock);
    kill_valid = 1'b0;
    check("kill_valid0", wr_valid, 0);
    check("kill_count3", count, 3);
    @(negedge clock);
    check("kill_count2", count, 2);
    expectWrite("kill_survivor", 32'h22);
    check("kill_valid_tail", wr_valid, 0);
    check("kill_count1", count, 1);
    @(negedge clock);
    check("kill_count0", count, 0);

    // Pointer wrap with streaming push/pop
    wr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      enq_vd = 5'd2; enq_groupCounter = 7'(i); enq_data = 32'h200 + 32'(i);
      enq_mask = 4'hF; enq_last = 1'b1; enq_instructionIndex = 3'd3; enq_valid = 1'b1;
      @(negedge clock);
      check("wrap_valid", wr_valid, 1);
      check("wrap_data", wr_data, 32'h200 + 32'(i));
      check("wrap_count", count, 1);
    end
    enq_valid = 1'b0;
    @(negedge clock);
    wr_ready = 1'b0;
    check("wrap_empty", count, 0);

    // Partial-mask writes to the same word
    pushOne(5'd3, 7'h02, 32'h0000BEEF, 4'h3, 1'b0, 3'd0);
    pushOne(5'd3, 7'h02, 32'hCAFE0000, 4'hC, 1'b0, 3'd0);
`ifdef LANE_VRF_WRITE_COALESCE_EN
    check("coal_count", count, 1);
    check("coal_mask", wr_mask, 4'hF);
    check("coal_data", wr_data, 32'hCAFEBEEF);
    expectWrite("coal_write", 32'hCAFEBEEF);
`else
    check("coal_count", count, 2);
    check("coal_mask", wr_mask, 4'h3);
    check("coal_data", wr_data, 32'h0000BEEF);
    expectWrite("coal_write0", 32'h0000BEEF);
    expectWrite("coal_write1", 32'hCAFE0000);
`endif
    check("coal_empty", count, 0);

    // Asynchronous reset with entries queued
    for (int i = 0; i < 3; i++) pushOne(5'd7, 7'(i * 8), 32'h300 + 32'(i), 4'hF, 1'b1, 3'd4);
    check("midrst_pre", count, 3);
    #2 reset = 1'b0;
    #1;
    check("midrst_valid", wr_valid, 0);
    check("midrst_count", count, 0);
    check("midrst_ready", enq_ready, 1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_after", count, 0);

    // Randomized traffic against a queue model
    for (int cyc = 0; cyc < 600; cyc++) begin
      mEnt_t n;
      bit popNow;
      bit pushNow;
      bit merged;
      logic [47:0] expHead;

      check("rnd_valid", wr_valid, (q.size() > 0 && !q[0].killed) ? 1 : 0);
      check("rnd_ready", enq_ready, (q.size() < 4) ? 1 : 0);
      check("rnd_count", count, q.size());
      if (q.size() > 0) begin
        expHead = {q[0].vd, q[0].off, q[0].mask, q[0].data, q[0].last, q[0].inst};
        check("rnd_head", {wr_vd, wr_offset, wr_mask, wr_data, wr_last, wr_instructionIndex}, expHead);
      end

      enq_valid = ($urandom % 3) != 0;
      wr_ready = ($urandom % 4) != 0;
      kill_valid = ($urandom % 8) == 0;
      kill_instructionIndex = 3'($urandom % 4);
      enq_vd = 5'($urandom % 4);
      enq_groupCounter = 7'($urandom % 16);
      enq_data = $urandom;
      enq_mask = 4'($urandom);
      enq_last = ($urandom % 3) == 0;
      enq_instructionIndex = 3'($urandom % 4);

      popNow = q.size() > 0 && (q[0].killed || wr_ready);
      pushNow = enq_valid && q.size() < 4;
      if (popNow) void'(q.pop_front());
      if (pushNow) begin
        n.vd = 5'((int'(enq_vd) + int'(enq_groupCounter) / 8) % 32);
        n.off = 3'(int'(enq_groupCounter) % 8);
        n.mask = enq_mask; n.data = enq_data; n.last = enq_last;
        n.inst = enq_instructionIndex; n.killed = 1'b0;
        merged = 1'b0;
`ifdef LANE_VRF_WRITE_COALESCE_EN
        if (q.size() > 0) begin
          int y;
          y = q.size() - 1;
          if (!q[y].killed && !q[y].last && q[y].vd == n.vd && q[y].off == n.off &&
              q[y].inst == n.inst) begin
            for (int b = 0; b < 4; b++)
              if (n.mask[b]) q[y].data[b*8 +: 8] = n.data[b*8 +: 8];
            q[y].mask = q[y].mask | n.mask;
            q[y].last = q[y].last | n.last;
            merged = 1'b1;
          end
        end
`endif
        if (!merged) q.push_back(n);
      end
      if (kill_valid) begin
        foreach (q[i]) if (q[i].inst == kill_instructionIndex) q[i].killed = 1'b1;
      end
      @(negedge clock);
    end
    enq_valid = 1'b0; kill_valid = 1'b0; wr_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lane_vrf_write_stage.md
# lane_vrf_write_stage

Parametrised final lane pipeline stage that turns execute results into VRF write requests. It maps a group counter to a (vd, offset) pair and buffers writes in a circular queue of configurable depth. It also supports per-instruction kill of queued writes and, optionally, coalescing of consecutive partial-mask writes to the same VRF word. It sits between the lane execute stage and the VRF write arbiter.

## Interface
Parameters:
- DATA_W, 32, write data width; multiple of 8; MASK_W = DATA_W/8
- GROUP_W, 7, group counter width
- OFFSET_W, 3, VRF offset width; < GROUP_W
- VD_W, 5, register index width
- INST_W, 3, instruction index width
- DEPTH, 4, queue entries; power of two, ≥ 2

Ports:
- clock  in  1  sole clock; all state rising-edge
- reset  in  1  asynchronous, active-low reset
- enq_valid / enq_ready  in / out  1 / 1  enqueue handshake
- enq_groupCounter  in  GROUP_W  element group counter
- enq_vd  in  VD_W  base destination register
- enq_data  in  DATA_W  result data
- enq_mask  in  MASK_W  byte enables
- enq_last  in  1  last write of instruction
- enq_instructionIndex  in  INST_W  owning instruction
- kill_valid  in  1  discard queued writes of one instruction
- kill_instructionIndex  in  INST_W  instruction to discard
- wr_valid / wr_ready  out / in  1 / 1  VRF write handshake
- wr_vd, wr_offset, wr_mask, wr_data, wr_last, wr_instructionIndex  out  VD_W, OFFSET_W, MASK_W, DATA_W, 1, INST_W  head entry fields
- count  out  $clog2(DEPTH)+1  occupied entries, killed entries included

## Operation
- Address mapping: offset = groupCounter[OFFSET_W-1:0]; vd = enq_vd + zero-extended groupCounter[GROUP_W-1:OFFSET_W], truncated mod 2^VD_W.
- Each entry stores {vd, offset, mask, data, last, instIdx, killed}. Head and tail pointers wrap mod DEPTH. A separate full bit disambiguates head == tail.
- enq_ready = ~full. It depends only on state, never on enq payload or wr_ready. A push occurs on enq_valid & enq_ready.
- Head is live when the queue is non-empty and not killed. wr_valid = head live. Pop occurs on wr_valid & wr_ready.
- A killed head is dropped silently, one per cycle, with no wr_valid.
- Kill: in the cycle kill_valid is high, every occupied entry whose instIdx matches gets killed set. An entry pushed in the same cycle with a matching index is also killed.
- Simultaneous push and pop: both take effect and count is unchanged. When full there is no push, so there is no bypass.
- enq_mask == 0 is still enqueued and issued (the VRF tracks last/instruction).

## Timing
- Enqueue-to-wr_valid latency is 1 cycle minimum; no combinational enq-to-wr path.
- wr_* are driven directly from head storage. They are stable while wr_valid & ~wr_ready.
- Kill takes effect on the next cycle's wr_valid. A head accepted in the kill cycle (wr_valid & wr_ready) is a completed write and is not revoked.
- Reset (asynchronous assert, synchronous-release use): pointers 0, full 0, all killed bits 0, count 0, wr_valid 0, enq_ready 1. wr_* data fields are 0. Reset mid-transfer discards all entries.
- Throughput: one push and one pop per cycle sustained with wr_ready high.

## Configuration
- LANE_VRF_WRITE_COALESCE_EN defined: a push merges into the youngest entry (tail−1) instead of allocating, when all of the following hold:
  - queue non-empty and youngest not being popped or dropped this cycle
  - youngest not killed and last == 0
  - same vd, offset and instIdx
- Merge rules: bytes with new mask set take new data; mask = old | new; last = old | enq_last. count is unchanged. enq_ready stays ~full, so a merge is never accepted when full.
- Undefined: every push allocates a new entry; no compare logic is built.

## Structure
- Package lane_vrf_write_pkg: entry struct typedef (parametrised via localparams mirroring module defaults), the address-map function, and the byte-merge function.
- One sub-module: lane_vrf_write_buffer (DEPTH-entry circular storage with pointers, full flag, kill marking and count). Mapping, coalescing and head-drop logic stay in the top.

## Test plan
- Map: vd=5, groupCounter=0x1B, data=0xA5A5A5A5, mask=0xF → next cycle wr_vd=8, wr_offset=3, wr_data=0xA5A5A5A5, wr_valid=1.
- Full: wr_ready=0, 4 pushes → count=4, enq_ready=0. 5th enq_valid held. One pop → enq_ready=1 next cycle, 5th accepted, order preserved.
- Kill: queue holds idx 1,2,1 and kill idx 1 → only idx 2 issued. Two killed entries drained with wr_valid=0, count reaches 0.
- Wrap: 10 push/pop pairs with DEPTH=4 and wr_ready=1 → data in order, count ≤ 1, no loss across pointer wrap.
- Coalesce (macro on): mask 0x3 data 0x0000BEEF then mask 0xC data 0xCAFE0000, same vd/offset/idx, wr_ready=0 → count=1, wr_mask=0xF, wr_data=0xCAFEBEEF. Macro off → count=2.
- Reset: assert reset with 3 entries queued → same cycle wr_valid=0, count=0, enq_ready=1.
